multicycle_decoder_ext: RTL and testbench
=========================================

# multicycle_decoder_ext

Parametrised next-generation control decoder for the multi-cycle ARM-subset core. Contains the main control FSM, an extended ALU decoder (EOR, MOV, CMP, TST, optional MUL), the PC-write logic and the instruction-field decoder. It drives the condition-logic block (PCS, NextPC, RegW, MemW, FlagW) and the datapath (mux selects, ALUControl, ImmSrc, RegSrc). It adds:

- an illegal-instruction path;
- flag-only compares that never write a register;
- an optional multi-cycle multiply state.

## Interface
Parameters:
- ALUCTRL_W, default 3: ALUControl width; legal values 2 (legacy ADD/SUB/AND/ORR only) or 3.
- MUL_LAT, default 4: cycles spent in MULEX, legal 1..15.
- STATE_W, default 4: width of the state debug output.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S.
- Rd  in  4  Instr[15:12].
- Instr74  in  4  Instr[7:4]; used only for MUL detection.
- PCS, NextPC, RegW, MemW  out  1 each  to condition logic.
- IRWrite, AdrSrc  out  1 each  datapath enables/selects.
- ResultSrc, ALUSrcA, ALUSrcB  out  2 each  datapath mux selects.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- ALUControl  out  ALUCTRL_W  ALU operation.
- ImmSrc, RegSrc  out  2 each  extend select / register-read selects.
- IllegalOp  out  1  one-cycle pulse in DECODE for an undecodable instruction.
- Busy  out  1  high while in MULEX.
- state  out  STATE_W  current state encoding.

## Operation
- Mux encodings:
  - ALUSrcA: 00=RD1, 01=PC.
  - ALUSrcB: 00=RD2, 01=ExtImm, 10=constant 4.
  - ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult.
- States and encodings, with Moore outputs (all unlisted outputs are 0):
  - FETCH=0: IRWrite, NextPC, A=01, B=10, Res=10.
  - DECODE=1: A=01, B=10, Res=10.
  - MEMADR=2: A=00, B=01.
  - MEMRD=3: AdrSrc, Res=00.
  - MEMWB=4: Res=01, RegW.
  - MEMWR=5: AdrSrc, MemW.
  - EXECR=6: A=00, B=00, ALUOp.
  - EXECI=7: A=00, B=01, ALUOp.
  - ALUWB=8: Res=00, RegW unless NoWrite.
  - BRANCH=9: A=00, B=01, Res=10, Branch.
  - MULEX=10: ALUOp, Busy.
  - UNKNOWN=11.
- Transitions:
  - FETCH→DECODE.
  - DECODE selects the next state:
    - Op=00, I=0 → EXECR.
    - Op=00, I=1 → EXECI.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=11 or illegal cmd → UNKNOWN.
  - MEMADR→MEMRD if Funct[0], else MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH.
  - EXECR/EXECI/MULEX→ALUWB→FETCH.
  - BRANCH→FETCH; UNKNOWN→FETCH.
  - Undefined encodings→FETCH.
- ALU decoder: applies when ALUOp is set; when ALUOp=0, ALUControl=0 and FlagW=00.
  - cmd 0100 ADD → 000.
  - cmd 0010 SUB → 001.
  - cmd 0000 AND → 010.
  - cmd 1100 ORR → 011.
  - cmd 0001 EOR → 100.
  - cmd 1101 MOV → 101.
  - cmd 1010 CMP → 001 with NoWrite.
  - cmd 1000 TST → 010 with NoWrite.
  - MUL → 110.
- With ALUCTRL_W=2, EOR, MOV and MUL are illegal.
- Any other cmd with Op=00 is illegal: IllegalOp pulses in DECODE, the FSM goes to UNKNOWN, and no write enable is asserted.
- FlagW[1]=S. FlagW[0]=S & (ADD|SUB|CMP). CMP and TST force S=1.
- PCS = ((Rd==4'hF) & RegW) | Branch. NoWrite also suppresses PCS.
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).

## Timing
- Reset: while reset=0, state←FETCH at each edge, and IRWrite, NextPC, RegW, MemW, PCS, IllegalOp and Busy are forced to 0. All other outputs are 0 during reset.
- The first fetch is the first edge after reset returns to 1.
- Reset mid-instruction aborts on that edge; no write enable is asserted in the reset cycle.
- Instruction latency in cycles:
  - data-processing: 4;
  - LDR: 5;
  - STR: 4;
  - B: 3;
  - illegal: 3;
  - MUL: 3+MUL_LAT.
- Outputs are purely combinational from state and instruction fields; no output registers.
- MULEX counter: loads MUL_LAT-1 on entry, decrements each cycle, and exits when it reaches 0. MUL_LAT=1 therefore stays exactly one cycle.

## Configuration
- DECODE_MUL_EN defined:
  - In DECODE, Op=00, Funct[5:4]=00 and Instr74=1001 → MULEX with ALUControl=110.
  - Funct[0] gives FlagW=10 (NZ only).
- DECODE_MUL_EN undefined:
  - Instr74 is ignored; the MULEX state and its counter are absent.
  - The pattern decodes as an ordinary register data-processing instruction.
  - Busy is tied to 0.

## Structure
- Shared package decode_pkg holds:
  - state encodings;
  - ALUControl codes;
  - mux-select encodings;
  - cmd constants.
- One sub-module, ctrl_fsm: state register, next-state logic, MUL counter and Moore outputs.
- The ALU decoder, PC logic and instruction decoder stay in the top module.

## Test plan
- Reset held 0 for 3 cycles with Op=00 → state=0, all enables 0; first cycle after release: IRWrite=1, NextPC=1.
- ADD R1 (Op=00, Funct=001001) → states 0,1,6,8,0; ALUControl=000 in EXECR; FlagW=11; RegW=1 in ALUWB.
- CMP (Funct=010101) → ALUControl=001, FlagW=11, RegW=0 and PCS=0 in ALUWB even with Rd=15.
- LDR (Op=01, Funct[0]=1) → states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 with RegW in MEMWB; Rd=15 gives PCS=1.
- Illegal cmd 0111 → IllegalOp=1 for one cycle in DECODE, then UNKNOWN, then FETCH; no RegW/MemW.
- DECODE_MUL_EN with MUL_LAT=4, Instr74=1001 → Busy high exactly 4 cycles, ALUControl=110, total 7 cycles; reset in the 2nd MULEX cycle → FETCH next cycle, RegW never asserted.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the multi-cycle ARM-subset control decoder.
// States, ALU codes, mux selects, cmd constants and the Moore control bundle.
package decode_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_MULEX   = 4'd10;
    localparam logic [3:0] S_UNKNOWN = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;

    localparam logic [1:0] SRCA_RD1      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] MUL_PATTERN = 4'b1001;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       reg_w;
        logic       mem_w;
        logic       alu_op;
        logic       branch;
        logic       busy;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

    // EOR and MOV only exist when the ALU control bus is wide enough to encode them.
    function automatic logic cmd_is_legal(input logic [3:0] cmd, input logic ext_ops);
        logic legal;
        legal = 1'b0;
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP, CMD_TST: legal = 1'b1;
            CMD_EOR, CMD_MOV:                                     legal = ext_ops;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ctrl_fsm.sv
// Main control FSM: state register, next-state logic, MUL counter and Moore outputs.
// The MULEX state and its counter exist only when DECODE_MUL_EN is defined.
module ctrl_fsm
    import decode_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       funct_i,
    input  logic       funct_s,
    input  logic       illegal,
    input  logic       is_mul,
    output logic [3:0] state,
    output ctrl_t      ctrl
);

    logic [3:0] state_q;
    logic [3:0] state_d;

`ifdef DECODE_MUL_EN
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
`else
    logic unused_fsm_inputs;
    assign unused_fsm_inputs = is_mul;
`endif

    always_comb begin
        state_d = state_q;
`ifdef DECODE_MUL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_UNKNOWN;
`ifdef DECODE_MUL_EN
                end else if (is_mul) begin
                    state_d = S_MULEX;
                    cnt_d   = MUL_LOAD;
`endif
                end else begin
                    case (op)
                        OP_DP:   state_d = funct_i ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_UNKNOWN;
                    endcase
                end
            end
            S_MEMADR:  state_d = funct_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_UNKNOWN: state_d = S_FETCH;
`ifdef DECODE_MUL_EN
            S_MULEX: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ALUWB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
`ifdef DECODE_MUL_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef DECODE_MUL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = 1'b1;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURESULT;
                ctrl.branch     = 1'b1;
            end
`ifdef DECODE_MUL_EN
            S_MULEX: begin
                ctrl.alu_op = 1'b1;
                ctrl.busy   = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/multicycle_decoder_ext.sv
// Control decoder top: ALU decoder, PC-write logic and instruction-field decoding around ctrl_fsm.
// Define DECODE_MUL_EN to add the multi-cycle multiply (MULEX) path.
module multicycle_decoder_ext
    import decode_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int MUL_LAT   = 4,
    parameter int STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           Instr74,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           FlagW,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic                 IllegalOp,
    output logic                 Busy,
    output logic [STATE_W-1:0]   state
);

    localparam logic EXT_OPS = (ALUCTRL_W >= 3);

    logic [3:0] cmd;
    logic       s_bit;
    logic       is_mul;
    logic       illegal;
    logic       no_write;
    logic       s_eff;
    logic [2:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       reg_w_int;
    logic       pcs_int;
    logic [3:0] fsm_state;
    ctrl_t      ctrl;

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];

`ifdef DECODE_MUL_EN
    assign is_mul = (Op == OP_DP) && (Funct[5:4] == 2'b00) && (Instr74 == MUL_PATTERN);
`else
    logic unused_instr74;
    assign unused_instr74 = ^Instr74;
    assign is_mul = 1'b0;
`endif

    // A multiply needs the 3-bit ALU code; with a 2-bit bus it is undecodable.
    assign illegal = (Op == 2'b11) ||
                     ((Op == OP_DP) && (is_mul ? !EXT_OPS : !cmd_is_legal(cmd, EXT_OPS)));

    assign no_write = (Op == OP_DP) && !is_mul && ((cmd == CMD_CMP) || (cmd == CMD_TST));
    assign s_eff    = s_bit || no_write;

    ctrl_fsm #(
        .MUL_LAT (MUL_LAT)
    ) u_ctrl_fsm (
        .clk     (clk),
        .reset   (reset),
        .op      (Op),
        .funct_i (Funct[5]),
        .funct_s (s_bit),
        .illegal (illegal),
        .is_mul  (is_mul),
        .state   (fsm_state),
        .ctrl    (ctrl)
    );

    always_comb begin
        alu_ctrl = ALU_ADD;
        flag_w   = 2'b00;
        if (ctrl.alu_op) begin
            if (is_mul) begin
                alu_ctrl = ALU_MUL;
                flag_w   = {s_bit, 1'b0};
            end else begin
                case (cmd)
                    CMD_ADD: alu_ctrl = ALU_ADD;
                    CMD_SUB: alu_ctrl = ALU_SUB;
                    CMD_AND: alu_ctrl = ALU_AND;
                    CMD_ORR: alu_ctrl = ALU_ORR;
                    CMD_EOR: alu_ctrl = ALU_EOR;
                    CMD_MOV: alu_ctrl = ALU_MOV;
                    CMD_CMP: alu_ctrl = ALU_SUB;
                    CMD_TST: alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
                flag_w[1] = s_eff;
                flag_w[0] = s_eff && ((cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP));
            end
        end
    end

    assign reg_w_int = ctrl.reg_w && !no_write;
    assign pcs_int   = (((Rd == 4'hF) && reg_w_int) || ctrl.branch) && !no_write;

    // Everything is held at zero while reset is low so an aborted instruction writes nothing.
    always_comb begin
        PCS        = 1'b0;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        FlagW      = 2'b00;
        ALUControl = '0;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        IllegalOp  = 1'b0;
        Busy       = 1'b0;
        state      = '0;
        if (reset) begin
            PCS        = pcs_int;
            NextPC     = ctrl.next_pc;
            RegW       = reg_w_int;
            MemW       = ctrl.mem_w;
            IRWrite    = ctrl.ir_write;
            AdrSrc     = ctrl.adr_src;
            ResultSrc  = ctrl.result_src;
            ALUSrcA    = ctrl.alu_src_a;
            ALUSrcB    = ctrl.alu_src_b;
            FlagW      = flag_w;
            ALUControl = alu_ctrl[ALUCTRL_W-1:0];
            ImmSrc     = Op;
            RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};
            IllegalOp  = (fsm_state == S_DECODE) && illegal;
            Busy       = ctrl.busy;
            state      = STATE_W'(fsm_state);
        end
    end

endmodule

// File: tb/tb_multicycle_decoder_ext.sv
// Directed self-checking bench for multicycle_decoder_ext with hand-computed expectations.
// MUL checks follow whichever way DECODE_MUL_EN is set for the build.
module tb_multicycle_decoder_ext;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Instr74;
    logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, IllegalOp, Busy;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, FlagW, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int assertCount = 0;
    int failCount   = 0;

    multicycle_decoder_ext #(
        .ALUCTRL_W (3),
        .MUL_LAT   (4),
        .STATE_W   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .Instr74    (Instr74),
        .PCS        (PCS),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .FlagW      (FlagW),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .IllegalOp  (IllegalOp),
        .Busy       (Busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input logic [3:0] i74);
        Op      = op;
        Funct   = funct;
        Rd      = rd;
        Instr74 = i74;
        #1;
    endtask

    // Advance one clock and sample clear of the edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic checkState(input string tag, input logic [3:0] expected);
        checkOutput(tag, {28'd0, state}, {28'd0, expected});
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(2'b00, 6'b000000, 4'd0, 4'd0);

        for (int i = 0; i < 3; i++) begin
            tick();
            checkState("reset state", 4'd0);
            checkOutput("reset enables", {26'd0, IRWrite, NextPC, RegW, MemW, PCS, IllegalOp}, 32'd0);
        end
        reset = 1'b1;
        #1;
        checkOutput("first fetch IRWrite", {31'd0, IRWrite}, 32'd1);
        checkOutput("first fetch NextPC", {31'd0, NextPC}, 32'd1);

        // ADD R1, S=1, register operand
        applyStimulus(2'b00, 6'b001001, 4'd1, 4'd0);
        checkOutput("fetch ALUSrcB", {30'd0, ALUSrcB}, 32'd2);
        tick(); checkState("add decode", 4'd1);
        checkOutput("add IllegalOp", {31'd0, IllegalOp}, 32'd0);
        tick(); checkState("add execr", 4'd6);
        checkOutput("add ALUControl", {29'd0, ALUControl}, 32'd0);
        checkOutput("add FlagW", {30'd0, FlagW}, 32'd3);
        checkOutput("add execr RegW", {31'd0, RegW}, 32'd0);
        tick(); checkState("add aluwb", 4'd8);
        checkOutput("add RegW", {31'd0, RegW}, 32'd1);
        checkOutput("add PCS", {31'd0, PCS}, 32'd0);
        checkOutput("add aluwb FlagW", {30'd0, FlagW}, 32'd0);
        tick(); checkState("add back to fetch", 4'd0);

        // CMP with Rd=15 must not write a register or the PC
        applyStimulus(2'b00, 6'b010101, 4'hF, 4'd0);
        tick(); checkState("cmp decode", 4'd1);
        tick(); checkState("cmp execr", 4'd6);
        checkOutput("cmp ALUControl", {29'd0, ALUControl}, 32'd1);
        checkOutput("cmp FlagW", {30'd0, FlagW}, 32'd3);
        tick(); checkState("cmp aluwb", 4'd8);
        checkOutput("cmp RegW", {31'd0, RegW}, 32'd0);
        checkOutput("cmp PCS", {31'd0, PCS}, 32'd0);
        tick(); checkState("cmp fetch", 4'd0);

        // TST with S=0 still sets NZ flags only
        applyStimulus(2'b00, 6'b010000, 4'd3, 4'd0);
        tick(); tick(); checkState("tst execr", 4'd6);
        checkOutput("tst ALUControl", {29'd0, ALUControl}, 32'd2);
        checkOutput("tst FlagW", {30'd0, FlagW}, 32'd2);
        tick(); checkOutput("tst RegW", {31'd0, RegW}, 32'd0);
        tick();

        // EOR register, S=1
        applyStimulus(2'b00, 6'b000011, 4'd2, 4'd0);
        tick(); tick(); checkState("eor execr", 4'd6);
        checkOutput("eor ALUControl", {29'd0, ALUControl}, 32'd4);
        checkOutput("eor FlagW", {30'd0, FlagW}, 32'd2);
        tick(); tick();

        // ADD immediate, S=0
        applyStimulus(2'b00, 6'b101000, 4'd4, 4'd0);
        tick(); tick(); checkState("addi execi", 4'd7);
        checkOutput("addi ALUSrcB", {30'd0, ALUSrcB}, 32'd1);
        checkOutput("addi FlagW", {30'd0, FlagW}, 32'd0);
        tick(); checkOutput("addi RegW", {31'd0, RegW}, 32'd1);
        tick(); checkState("addi fetch", 4'd0);

        // LDR into PC
        applyStimulus(2'b01, 6'b011001, 4'hF, 4'd0);
        tick(); checkState("ldr decode", 4'd1);
        checkOutput("ldr RegSrc", {30'd0, RegSrc}, 32'd2);
        checkOutput("ldr ImmSrc", {30'd0, ImmSrc}, 32'd1);
        tick(); checkState("ldr memadr", 4'd2);
        checkOutput("ldr ALUSrcB", {30'd0, ALUSrcB}, 32'd1);
        tick(); checkState("ldr memrd", 4'd3);
        checkOutput("ldr AdrSrc", {31'd0, AdrSrc}, 32'd1);
        tick(); checkState("ldr memwb", 4'd4);
        checkOutput("ldr ResultSrc", {30'd0, ResultSrc}, 32'd1);
        checkOutput("ldr RegW", {31'd0, RegW}, 32'd1);
        checkOutput("ldr PCS", {31'd0, PCS}, 32'd1);
        tick(); checkState("ldr fetch", 4'd0);

        // STR
        applyStimulus(2'b01, 6'b011000, 4'd2, 4'd0);
        tick(); tick(); tick(); checkState("str memwr", 4'd5);
        checkOutput("str MemW", {31'd0, MemW}, 32'd1);
        checkOutput("str RegW", {31'd0, RegW}, 32'd0);
        tick(); checkState("str fetch", 4'd0);

        // B
        applyStimulus(2'b10, 6'b100000, 4'd0, 4'd0);
        tick(); checkOutput("b RegSrc", {30'd0, RegSrc}, 32'd1);
        tick(); checkState("b branch", 4'd9);
        checkOutput("b PCS", {31'd0, PCS}, 32'd1);
        checkOutput("b ResultSrc", {30'd0, ResultSrc}, 32'd2);
        tick(); checkState("b fetch", 4'd0);

        // Illegal cmd 0111
        applyStimulus(2'b00, 6'b001110, 4'd1, 4'd0);
        tick(); checkState("ill decode", 4'd1);
        checkOutput("ill IllegalOp", {31'd0, IllegalOp}, 32'd1);
        tick(); checkState("ill unknown", 4'd11);
        checkOutput("ill pulse ends", {31'd0, IllegalOp}, 32'd0);
        checkOutput("ill writes", {30'd0, RegW, MemW}, 32'd0);
        tick(); checkState("ill fetch", 4'd0);

        // Op=11 is undecodable
        applyStimulus(2'b11, 6'b000000, 4'd1, 4'd0);
        tick(); checkOutput("op11 IllegalOp", {31'd0, IllegalOp}, 32'd1);
        tick(); checkState("op11 unknown", 4'd11);
        tick(); checkState("op11 fetch", 4'd0);

        // Multiply pattern: AND-shaped Funct with Instr74=1001, S=1
        applyStimulus(2'b00, 6'b000001, 4'd5, 4'b1001);
        tick(); checkState("mul decode", 4'd1);
`ifdef DECODE_MUL_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            checkState("mul mulex", 4'd10);
            checkOutput("mul Busy", {31'd0, Busy}, 32'd1);
            checkOutput("mul ALUControl", {29'd0, ALUControl}, 32'd6);
            checkOutput("mul FlagW", {30'd0, FlagW}, 32'd2);
        end
        tick(); checkState("mul aluwb", 4'd8);
        checkOutput("mul Busy after", {31'd0, Busy}, 32'd0);
        checkOutput("mul RegW", {31'd0, RegW}, 32'd1);
        tick(); checkState("mul fetch", 4'd0);

        // Reset during the second MULEX cycle aborts the multiply
        tick(); tick(); tick(); checkState("mulrst 2nd mulex", 4'd10);
        reset = 1'b0;
        #1;
        checkOutput("mulrst RegW", {31'd0, RegW}, 32'd0);
        checkOutput("mulrst Busy", {31'd0, Busy}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        checkState("mulrst fetch", 4'd0);
        checkOutput("mulrst IRWrite", {31'd0, IRWrite}, 32'd1);
        checkOutput("mulrst RegW after", {31'd0, RegW}, 32'd0);
`else
        tick(); checkState("mul-off execr", 4'd6);
        checkOutput("mul-off ALUControl", {29'd0, ALUControl}, 32'd2);
        checkOutput("mul-off FlagW", {30'd0, FlagW}, 32'd2);
        checkOutput("mul-off Busy", {31'd0, Busy}, 32'd0);
        tick(); checkState("mul-off aluwb", 4'd8);
        tick(); checkState("mul-off fetch", 4'd0);

        // Mid-instruction reset aborts an ordinary ALU op
        tick(); tick(); checkState("rst execr", 4'd6);
        reset = 1'b0;
        #1;
        checkOutput("rst RegW", {31'd0, RegW}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        checkState("rst fetch", 4'd0);
        checkOutput("rst IRWrite", {31'd0, IRWrite}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
